// File: rtl/vga_fb_reader_if.sv
// Framebuffer read port and DAC pins of the VGA scan-out stage.
// No valid/ready: the reader issues one address per pixel clock, the RAM answers one cycle later, and the pins never stall.
interface vga_fb_reader_if;
  logic [18:0] ram_rdaddr;
  logic [7:0]  ram_q;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [7:0]  pixel;
  logic        frame_start;

  modport master (
    output ram_rdaddr, hsync, vsync, blank_n, pixel, frame_start,
    input  ram_q
  );

  modport slave (
    input  ram_rdaddr, hsync, vsync, blank_n, pixel, frame_start,
    output ram_q
  );
endinterface

// File: rtl/vga_fb_reader.sv
// 640x480@60 VGA scan-out: centres a runtime-sized grayscale framebuffer image and drives sync/blank/pixel.
// Optional: define VGA_BORDER_EN to draw an 8'hFF 1-pixel ring around the image window.
module vga_fb_reader #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter logic [7:0] BG_PIXEL = 8'h00
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:0]      img_w,
  input  logic [9:0]      img_h,
  vga_fb_reader_if.master bus
);

  localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);

  logic [9:0]  h, v;
  logic        frame_latch, frame_end;
  logic [10:0] lat_w, lat_h, lat_x0, lat_y0;
  logic [10:0] cur_w, cur_h, x0, y0;
  logic [10:0] win_w, win_h, win_x0, win_y0;
  logic [10:0] h_ext, v_ext;
  logic        in_win, hs_raw, vs_raw, blank_raw;
  logic [18:0] addr;
  logic        win_d1, hs_d1, vs_d1, blank_d1, fs_d1;
  logic [7:0]  pix_sel;

  assign frame_latch = (h == 10'd0) && (v == 10'd0);
  assign frame_end   = (h == H_LAST) && (v == V_LAST);
  assign h_ext       = {1'b0, h};
  assign v_ext       = {1'b0, v};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (h == H_LAST) begin
      h <= 10'd0;
      v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // The latch cycle itself already uses the freshly sampled window, so pixel (0,0) is correct for full-size images.
  always_comb begin
    lat_w  = ({1'b0, img_w} > H_ACT_W) ? H_ACT_W : {1'b0, img_w};
    lat_h  = ({1'b0, img_h} > V_ACT_W) ? V_ACT_W : {1'b0, img_h};
    lat_x0 = (H_ACT_W - lat_w) >> 1;
    lat_y0 = (V_ACT_W - lat_h) >> 1;
    win_w  = frame_latch ? lat_w  : cur_w;
    win_h  = frame_latch ? lat_h  : cur_h;
    win_x0 = frame_latch ? lat_x0 : x0;
    win_y0 = frame_latch ? lat_y0 : y0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_w <= 11'd0;
      cur_h <= 11'd0;
      x0    <= 11'd0;
      y0    <= 11'd0;
    end else if (frame_latch) begin
      cur_w <= lat_w;
      cur_h <= lat_h;
      x0    <= lat_x0;
      y0    <= lat_y0;
    end
  end

  assign in_win = (h_ext >= win_x0) && (h_ext < win_x0 + win_w) &&
                  (v_ext >= win_y0) && (v_ext < win_y0 + win_h);

  // Cleared on the last cycle of a frame so the latch cycle already presents address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         addr <= 19'd0;
    else if (frame_end) addr <= 19'd0;
    else if (in_win)    addr <= addr + 19'd1;
  end

  assign bus.ram_rdaddr = addr;

  assign hs_raw    = !((h >= HS_START) && (h < HS_END));
  assign vs_raw    = !((v >= VS_START) && (v < VS_END));
  assign blank_raw = (h < H_ACT) && (v < V_ACT);

`ifdef VGA_BORDER_EN
  logic in_ring, ring_d1;

  assign in_ring = (win_w != 11'd0) && (win_h != 11'd0) && !in_win &&
                   (h_ext + 11'd1 >= win_x0) && (h_ext <= win_x0 + win_w) &&
                   (v_ext + 11'd1 >= win_y0) && (v_ext <= win_y0 + win_h);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ring_d1 <= 1'b0;
    else        ring_d1 <= in_ring;
  end
`endif

  // First delay stage runs alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_d1   <= 1'b0;
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      blank_d1 <= 1'b0;
      fs_d1    <= 1'b0;
    end else begin
      win_d1   <= in_win;
      hs_d1    <= hs_raw;
      vs_d1    <= vs_raw;
      blank_d1 <= blank_raw;
      fs_d1    <= frame_latch;
    end
  end

  always_comb begin
    pix_sel = 8'h00;
    if (blank_d1) begin
      if (win_d1) pix_sel = bus.ram_q;
`ifdef VGA_BORDER_EN
      else if (ring_d1) pix_sel = 8'hFF;
`endif
      else pix_sel = BG_PIXEL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.blank_n     <= 1'b0;
      bus.pixel       <= 8'h00;
      bus.frame_start <= 1'b0;
    end else begin
      bus.hsync       <= hs_d1;
      bus.vsync       <= vs_d1;
      bus.blank_n     <= blank_d1;
      bus.pixel       <= pix_sel;
      bus.frame_start <= fs_d1;
    end
  end

endmodule
